// File: rtl/serializer_arbiter.sv
// serializer_arbiter: 4-way round-robin arbiter feeding an LSB-first
// byte serializer. States IDLE -> SHIFT -> GAP -> IDLE; when GAP=0 the
// last SHIFT bit-time can accept the next frame so frames run back-to-back.
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity
// bit-time (9-bit frames).
module serializer_arbiter #(
  parameter int GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        serial_out,
  output logic        ser_valid,
  output logic        ser_last,
  output logic [1:0]  ser_src,
  output logic        busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr;
  logic [3:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic [7:0]  shreg;
  logic [1:0]  src;
  logic [3:0]  grant;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;
  logic        free;
  logic        accept;

  // Arbiter may take a new byte in IDLE, or on the final bit-time when no gap follows.
  assign free   = (state == S_IDLE) ||
                  ((GAP == 0) && (state == S_SHIFT) && (bit_cnt == LAST_BIT));
  assign accept = |req_ready;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    grant = '0;
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Strobe is gated by reset and enable so nothing is accepted while frozen.
  assign req_ready = (rst_n && en && free) ? grant : 4'b0000;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a low enable holds the current state.
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        S_IDLE:  if (accept) state_nxt = S_SHIFT;
        S_SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            if (GAP == 0) state_nxt = accept ? S_SHIFT : S_IDLE;
            else          state_nxt = S_GAP;
          end
        end
        S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: byte capture, winner/pointer update, bit and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 2'd0;
      bit_cnt <= 4'd0;
      gap_cnt <= 4'd0;
      shreg   <= 8'd0;
      src     <= 2'd0;
    end else if (en) begin
      if (accept) begin
        shreg   <= req_data[{win, 3'b000} +: 8];
        src     <= win;
        ptr     <= win + 2'd1;
        bit_cnt <= 4'd0;
      end else if (state == S_SHIFT) begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= 4'd0;
          gap_cnt <= 4'd0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end
    end
  end

  // Outputs decode straight from state, so a frozen state freezes the outputs.
  always_comb begin
    serial_out = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    ser_src    = src;
    busy       = (state != S_IDLE);
    if (state == S_SHIFT) begin
      ser_valid = 1'b1;
      ser_last  = (bit_cnt == LAST_BIT);
`ifdef SERIALIZER_PARITY_EN
      serial_out = bit_cnt[3] ? ^shreg : shreg[bit_cnt[2:0]];
`else
      serial_out = shreg[bit_cnt[2:0]];
`endif
    end
  end

endmodule
